// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall, flush and redirect control for the SampleCPU pipeline.
// Any stage may request a stall, and the controller holds that stage and every
// younger stage. An exception from stage EXC_STAGE freezes the pipe for one cycle.
// The following cycle is a single FLUSH cycle that drives the latched redirect PC.
// A sticky watchdog flags a pipeline that stays stalled for WDOG_LIMIT cycles.
// Optional build macro: STALL_PERF_EN adds a saturating stall-cycle counter.
// When STALL_PERF_EN is undefined, stall_cycles is tied to zero.

module pipeline_hazard_ctrl #(
  parameter int STALL_W    = 6,
  parameter int EXC_STAGE  = 4,
  parameter int PC_W       = 32,
  parameter int WDOG_W     = 8,
  parameter int WDOG_LIMIT = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stallreq,
  input  logic               excp_req,
  input  logic [PC_W-1:0]    excp_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [PC_W-1:0]    new_pc,
  output logic               busy,
  output logic               wdog_trip,
  output logic [31:0]        stall_cycles
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [WDOG_W-1:0] WDOG_PRE = WDOG_W'(WDOG_LIMIT - 1);

  state_t             state;
  logic [STALL_W-1:0] therm;
  logic [STALL_W-1:0] exc_mask;
  logic [STALL_W-1:0] stall_raw;
  logic [WDOG_W-1:0]  wdog_cnt;

  // Stall bus: thermometer below the oldest requester, or a freeze up to the excepting stage
  always_comb begin
    therm     = '0;
    exc_mask  = '0;
    stall_raw = '0;
    for (int k = 0; k < STALL_W; k++) begin
      therm[k]    = |(stallreq >> k);
      exc_mask[k] = (k <= EXC_STAGE);
    end
    if (state == RUN) begin
      stall_raw = excp_req ? exc_mask : therm;
    end
  end

  assign stall = rst ? '0 : stall_raw;
  assign flush = !rst && (state == FLUSH);
  assign busy  = !rst && (state != RUN);

  // FSM with the redirect PC latch; an exception in RUN always leads to exactly one FLUSH
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      new_pc <= '0;
    end else begin
      case (state)
        RUN: begin
          if (excp_req) begin
            new_pc <= excp_pc;
            state  <= FLUSH;
          end
        end
        FLUSH: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Watchdog: counts consecutive stalled RUN cycles and sets a sticky trip flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else if ((state == RUN) && (stall_raw != '0)) begin
      if (wdog_cnt != '1) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (wdog_cnt == WDOG_PRE) begin
        wdog_trip <= 1'b1;
      end
    end else begin
      wdog_cnt <= '0;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_cnt;

  // Performance counter: counts cycles in which the PC stage is held, and saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (stall_raw[0] && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign stall_cycles = perf_cnt;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl.
// Inputs change on the falling edge. Outputs are sampled 1ns after each change.

module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  stallreq;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
  logic        wdog_trip;
  logic [31:0] stall_cycles;

  int n_compared;
  int n_mismatched;

  pipeline_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq     (stallreq),
    .excp_req     (excp_req),
    .excp_pc      (excp_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .busy         (busy),
    .wdog_trip    (wdog_trip),
    .stall_cycles (stall_cycles)
  );

  // 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stallreq = '0; excp_req = 1'b0; excp_pc = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1; stallreq = 6'b111111; excp_req = 1'b1; excp_pc = 32'hDEAD_BEEF;
      #1;
      n_compared++;
      if ({stall, flush, busy, wdog_trip} !== 9'b0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_hold: got stall=%b flush=%b busy=%b trip=%b, want all 0", stall, flush, busy, wdog_trip);
      end
    end
    @(negedge clk);
    rst = 1'b0; stallreq = '0; excp_req = 1'b0; excp_pc = '0;
    #1;
    n_compared++;
    if ({stall, flush, busy, wdog_trip} !== 9'b0 || new_pc !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_after: got stall=%b flush=%b busy=%b trip=%b new_pc=%h, want all 0", stall, flush, busy, wdog_trip, new_pc);
    end
  endtask

  task automatic test_stall_encode();
    logic [5:0] req_v [4] = '{6'b000100, 6'b001010, 6'b000000, 6'b100001};
    logic [5:0] exp_v [4] = '{6'b000111, 6'b001111, 6'b000000, 6'b111111};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      stallreq = req_v[i];
      #1;
      n_compared++;
      if (stall !== exp_v[i] || flush !== 1'b0 || busy !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL stall_encode[%0d]: got stall=%b flush=%b busy=%b, want stall=%b flush=0 busy=0", i, stall, flush, busy, exp_v[i]);
      end
    end
  endtask

  task automatic test_exception();
    @(negedge clk);
    stallreq = 6'b001000; excp_req = 1'b1; excp_pc = 32'hBFC0_0380;
    #1;
    n_compared++;
    if (stall !== 6'b011111 || flush !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL exc_freeze: got stall=%b flush=%b, want stall=011111 flush=0", stall, flush);
    end
    @(negedge clk);
    stallreq = 6'b111111; excp_req = 1'b0; excp_pc = 32'h1234_5678;
    #1;
    n_compared++;
    if (flush !== 1'b1 || new_pc !== 32'hBFC0_0380 || stall !== 6'b0 || busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL exc_flush: got flush=%b new_pc=%h stall=%b busy=%b, want 1 bfc00380 000000 1", flush, new_pc, stall, busy);
    end
    @(negedge clk);
    stallreq = '0;
    #1;
    n_compared++;
    if (flush !== 1'b0 || busy !== 1'b0 || new_pc !== 32'hBFC0_0380) begin
      n_mismatched++;
      $display("[TB] FAIL exc_after: got flush=%b busy=%b new_pc=%h, want 0 0 bfc00380", flush, busy, new_pc);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    excp_req = 1'b1; excp_pc = 32'h0000_1000;
    @(negedge clk);
    excp_pc = 32'h0000_2000;
    #1;
    n_compared++;
    if (flush !== 1'b1 || new_pc !== 32'h0000_1000) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_first: got flush=%b new_pc=%h, want 1 00001000", flush, new_pc);
    end
    @(negedge clk);
    excp_req = 1'b0;
    #1;
    n_compared++;
    if (flush !== 1'b0 || busy !== 1'b0 || new_pc !== 32'h0000_1000) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_dropped: got flush=%b busy=%b new_pc=%h, want 0 0 00001000", flush, busy, new_pc);
    end
    @(negedge clk);
    excp_req = 1'b1; excp_pc = 32'h0000_3000;
    @(negedge clk);
    excp_req = 1'b0; rst = 1'b1;
    #1;
    n_compared++;
    if (flush !== 1'b0 || busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL flush_rst_force: got flush=%b busy=%b, want 0 0", flush, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_compared++;
    if (flush !== 1'b0 || busy !== 1'b0 || new_pc !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL flush_rst_abort: got flush=%b busy=%b new_pc=%h, want 0 0 00000000", flush, busy, new_pc);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      stallreq = 6'b001000;
      #1;
      n_compared++;
      if (wdog_trip !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL wdog_early[%0d]: got trip=%b, want 0", i, wdog_trip);
      end
    end
    @(negedge clk);
    stallreq = '0;
    #1;
    n_compared++;
    if (wdog_trip !== 1'b1 || stall !== 6'b0) begin
      n_mismatched++;
      $display("[TB] FAIL wdog_trip: got trip=%b stall=%b, want 1 000000", wdog_trip, stall);
    end
    repeat (3) @(negedge clk);
    #1;
    n_compared++;
    if (wdog_trip !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL wdog_sticky: got trip=%b, want 1", wdog_trip);
    end
    do_reset();
    #1;
    n_compared++;
    if (wdog_trip !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL wdog_rst: got trip=%b, want 0", wdog_trip);
    end
    for (int i = 1; i <= 149; i++) begin
      @(negedge clk);
      stallreq = 6'b001000;
    end
    @(negedge clk);
    stallreq = '0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      stallreq = 6'b001000;
      #1;
      n_compared++;
      if (wdog_trip !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL wdog_gap[%0d]: got trip=%b, want 0", i, wdog_trip);
      end
    end
    @(negedge clk);
    stallreq = '0;
    #1;
    n_compared++;
    if (wdog_trip !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL wdog_gap_trip: got trip=%b, want 1", wdog_trip);
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_cnt;
`ifdef STALL_PERF_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    do_reset();
    #1;
    n_compared++;
    if (stall_cycles !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL perf_rst: got %0d, want 0", stall_cycles);
    end
    repeat (10) begin
      @(negedge clk);
      stallreq = 6'b000100;
    end
    @(negedge clk);
    stallreq = '0;
    #1;
    n_compared++;
    if (stall_cycles !== exp_cnt) begin
      n_mismatched++;
      $display("[TB] FAIL perf_count: got %0d, want %0d", stall_cycles, exp_cnt);
    end
  endtask

  // Runs each scenario in sequence and then prints the summary line
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst      = 1'b1;
    stallreq = 6'b111111;
    excp_req = 1'b1;
    excp_pc  = 32'h0;
    test_reset();
    test_stall_encode();
    test_exception();
    test_back_to_back();
    test_watchdog();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the SampleCPU core.
- Generalises the load-use-only stall controller in three ways:
  - Any pipeline stage may request a stall.
  - An exception/redirect from a designated stage produces a one-cycle flush and a new PC.
  - A stall watchdog flags a pipeline wedged in stall.
- Sits beside the datapath; drives the stall bus and flush/new_pc into PC, IF, ID, EX, MEM, WB.

Parameters:
- STALL_W, 6, stall bus width = number of pipeline stages. Bit 0 = PC, bit 1 = IF, rising toward WB.
- EXC_STAGE, 4, index of the stage that raises exceptions (MEM). Must satisfy 0 <= EXC_STAGE < STALL_W.
- PC_W, 32, PC width.
- WDOG_W, 8, watchdog counter width.
- WDOG_LIMIT, 200, consecutive stall cycles that trip the watchdog. Must satisfy 1 <= WDOG_LIMIT <= 2^WDOG_W-1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- stallreq  in  STALL_W  bit k = stage k requests stall (load-use from ID = bit 2, multi-cycle EX = bit 3, ...)
- excp_req  in  1  exception/redirect request from stage EXC_STAGE, sampled each cycle
- excp_pc  in  PC_W  handler/target PC, valid with excp_req
- stall  out  STALL_W  stall bus; bit k = 1 holds stage k
- flush  out  1  one-cycle flush of all stages
- new_pc  out  PC_W  redirect PC, valid while flush = 1
- busy  out  1  1 while FSM is not in RUN
- wdog_trip  out  1  sticky watchdog flag
- stall_cycles  out  32  stall performance counter (see Optional Feature)

Behaviour:
- Reset
  - While rst = 1, stall, flush and busy are forced to 0 combinationally.
  - On the reset edge: FSM <= RUN, new_pc <= 0, latched PC <= 0, watchdog count <= 0, wdog_trip <= 0, stall_cycles <= 0.
  - Reset mid-FLUSH aborts the flush. No flush pulse follows reset.
- FSM states: RUN, FLUSH.
- RUN, excp_req = 0
  - k = index of highest set bit in stallreq.
  - stall[k:0] = 1, stall[STALL_W-1:k+1] = 0. This is combinational, zero latency.
  - stallreq = 0 gives stall = 0.
  - Example: stallreq = 6'b000100 gives stall = 6'b000111, identical to the legacy load-use encoding.
- RUN, excp_req = 1
  - excp_req has priority over every stallreq bit.
  - stall[EXC_STAGE:0] = 1, upper bits 0. The excepting stage and all younger stages freeze for this cycle.
  - excp_pc is latched; next state = FLUSH.
- FLUSH (exactly 1 cycle)
  - flush = 1, new_pc = latched PC, stall = 0, busy = 1.
  - excp_req and stallreq are ignored; a request arriving here is dropped.
  - Next state = RUN.
  - In RUN: flush = 0, busy = 0, new_pc holds its last value.
- Watchdog
  - Counts in RUN on every cycle with stall != 0; clears to 0 on any cycle with stall == 0 or in FLUSH.
  - The counter saturates.
  - wdog_trip is set on the edge where the count reaches WDOG_LIMIT, i.e. after the WDOG_LIMIT-th consecutive stall cycle.
  - wdog_trip stays 1 until rst. It does not alter the stall output.
- Timing: no combinational path from excp_pc to any output; new_pc is registered.

Optional Feature:
- Macro: STALL_PERF_EN.
- Defined:
  - stall_cycles increments by 1 on each cycle with stall[0] = 1 and rst = 0.
  - It saturates at 32'hFFFF_FFFF and clears only on rst.
- Undefined:
  - No counter flops; stall_cycles is tied to 32'h0.
  - All other behaviour is identical.

Test Plan:
- Reset with stallreq = 6'b111111, excp_req = 1 and rst = 1 for 3 cycles, then rst = 0 with all inputs 0 -> stall = 0, flush = 0, busy = 0 and wdog_trip = 0 during reset, and stall = 0, flush = 0, busy = 0, wdog_trip = 0, new_pc = 0 on the first cycle after.
- stallreq = 6'b000100 -> stall = 6'b000111. stallreq = 6'b001010 -> stall = 6'b001111. stallreq = 0 -> stall = 0. All same cycle.
- excp_req = 1, excp_pc = 32'hBFC0_0380, stallreq = 6'b001000 -> that cycle stall = 6'b011111. Next cycle flush = 1, new_pc = 32'hBFC0_0380, stall = 0, busy = 1. Following cycle flush = 0, busy = 0.
- excp_req held high for 2 cycles -> exactly one flush pulse; the second request (arriving in FLUSH) is dropped. Then excp_req = 1 with rst asserted during the FLUSH cycle -> no flush in the cycle after reset.
- stallreq[3] = 1 for 200 consecutive cycles -> wdog_trip rises after cycle 200 and stays 1 after stallreq clears. A gap of one stall-free cycle at cycle 150 -> no trip until 200 further stall cycles.
- With STALL_PERF_EN, 10 cycles of stallreq = 6'b000100 -> stall_cycles = 10. Without the macro -> stall_cycles = 0.
